// File: rtl/rfphoenix_mem_responder.sv
// rfphoenix_mem_responder: memory-side slave for the MemoryRequest/MemoryResponse
// protocol. Requests are queued in a small FIFO and then served in order against a
// 512-bit-line on-chip RAM. Each serviced request returns one response under a
// valid/ack handshake.
// Optional feature macro: RFPHOENIX_STORE_ACK_EN. When it is defined, successful
// stores return a response. When it is undefined, successful stores complete with
// no response.

package rfphoenix_mem_pkg;

  typedef enum logic [3:0] {
    MR_NOP   = 4'd0,
    MR_LOAD  = 4'd1,
    MR_LOADZ = 4'd2,
    MR_STORE = 4'd3,
    MR_TLB   = 4'd4,
    MR_CACHE = 4'd5
  } mem_func_t;

  typedef enum logic [7:0] {
    FLT_NONE  = 8'h00,
    FLT_UNIMP = 8'h37,
    FLT_PMA   = 8'h3D
  } fault_t;

  typedef struct packed {
    logic         v;
    logic [7:0]   tid;
    logic [3:0]   thread;
    logic [1:0]   omode;
    logic [31:0]  ip;
    logic [5:0]   step;
    logic         wr;
    mem_func_t    func;
    logic [3:0]   func2;
    logic [2:0]   sz;
    logic [63:0]  sel;
    logic [9:0]   asid;
    logic [31:0]  vcadr;
    logic [3:0]   acr;
    logic [3:0]   tgt;
    logic [31:0]  adr;
    logic [511:0] dat;
  } memory_request_t;

  typedef struct packed {
    logic          v;
    logic [7:0]    tid;
    logic [3:0]    thread;
    logic [1:0]    omode;
    logic [31:0]   ip;
    logic [5:0]    step;
    logic          wr;
    mem_func_t     func;
    logic [3:0]    func2;
    logic [2:0]    sz;
    logic [63:0]   sel;
    logic [9:0]    asid;
    logic [31:0]   vcadr;
    logic [3:0]    acr;
    logic [3:0]    tgt;
    logic [31:0]   badAddr;
    logic          cmt;
    logic          empty;
    logic          tlb_access;
    logic          ptgram_en;
    logic          rgn_en;
    logic          pmtram_ena;
    logic          dchit;
    logic [1:0]    hit;
    fault_t        cause;
    logic [31:0]   dat;
    logic [1023:0] res;
  } memory_response_t;

endpackage

module rfphoenix_mem_responder
  import rfphoenix_mem_pkg::*;
#(
  parameter int          LINES  = 1024,
  parameter int          QDEPTH = 4,
  parameter logic [31:0] BASE   = 32'h00000000
) (
  input  logic             clk,
  input  logic             rst,
  input  memory_request_t  req_i,
  output logic             req_full_o,
  output memory_response_t resp_o,
  input  logic             resp_ack_i,
  output logic             ovf_o
);

`ifdef RFPHOENIX_STORE_ACK_EN
  localparam bit STORE_ACK = 1'b1;
`else
  localparam bit STORE_ACK = 1'b0;
`endif

  localparam int          LW    = $clog2(LINES);
  localparam int          PW    = $clog2(QDEPTH);
  localparam int          CW    = PW + 1;
  localparam logic [32:0] LIMIT = 33'(BASE) + 33'(LINES) * 33'd64;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_RESP} state_t;

  // Request FIFO and working state
  memory_request_t  r_fifo [QDEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_ovf;
  memory_request_t  r_work;
  memory_response_t r_resp;

  // Line RAM and its registered read port
  logic [511:0]     r_mem [LINES];
  logic [511:0]     r_line;

  // FSM state. r_phase splits RD into an access cycle and a format cycle.
  state_t           r_state, w_state_next;
  logic             r_phase, w_phase_next;

  logic             w_push, w_pop, w_access, w_resp_load, w_resp_clr;
  logic [CW-1:0]    w_count_next;
  logic [LW-1:0]    w_line_idx;
  logic             w_in_range, w_is_load, w_is_store, w_store_wr, w_silent_store;
  memory_response_t w_resp;

  assign w_push         = req_i.v & ~r_full;
  assign w_line_idx     = r_work.adr[6 +: LW];
  assign w_in_range     = (r_work.adr >= BASE) && ({1'b0, r_work.adr} < LIMIT);
  assign w_is_load      = (r_work.func == MR_LOAD) || (r_work.func == MR_LOADZ);
  assign w_is_store     = (r_work.func == MR_STORE);
  assign w_store_wr     = r_work.v & w_is_store & w_in_range;
  assign w_silent_store = w_is_store & w_in_range & ~STORE_ACK;

  assign req_full_o = r_full;
  assign ovf_o      = r_ovf;
  assign resp_o     = r_resp;

  // FIFO occupancy after this cycle's push/pop pair
  always_comb begin
    // NOTE: every signal driven in a combinational block gets a default first so no latch is inferred.
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
    if (rst) begin
      r_state <= S_IDLE;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
    end
  end

  // FSM next-state and control strobes
  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_pop        = 1'b0;
    w_access     = 1'b0;
    w_resp_load  = 1'b0;
    w_resp_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_state_next = S_RD;
          w_phase_next = 1'b0;
        end
      end
      S_RD: begin
        if (!r_phase) begin
          w_access = 1'b1;
          if (w_silent_store) w_state_next = S_IDLE;
          else                w_phase_next = 1'b1;
        end else begin
          w_resp_load  = 1'b1;
          w_state_next = S_RESP;
          w_phase_next = 1'b0;
        end
      end
      S_RESP: begin
        if (resp_ack_i) begin
          w_resp_clr   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // FIFO control, overflow flag and response register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_ovf        <= 1'b0;
      r_resp       <= '0;
      r_resp.empty <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == CW'(QDEPTH));
      r_ovf   <= r_ovf | (req_i.v & r_full);
      if (w_resp_load)     r_resp   <= w_resp;
      else if (w_resp_clr) r_resp.v <= 1'b0;
    end
  end

  // FIFO storage and working register
  always_ff @(posedge clk) begin
    // NOTE: storage arrays carry no reset; pointers and count decide which entries are meaningful.
    if (w_push) r_fifo[r_wr_ptr] <= req_i;
    if (w_pop)  r_work           <= r_fifo[r_rd_ptr];
  end

  // Line RAM: synchronous read plus byte-enabled write in the RD access cycle
  always_ff @(posedge clk) begin
    if (w_access) begin
      r_line <= r_mem[w_line_idx];
      if (w_store_wr) begin
        for (int i = 0; i < 64; i++) begin
          if (r_work.sel[i]) r_mem[w_line_idx][8*i +: 8] <= r_work.dat[8*i +: 8];
        end
      end
    end
  end

  // Response formatting from the working request and the read line
  always_comb begin
    w_resp         = '0;
    w_resp.v       = 1'b1;
    w_resp.tid     = r_work.tid;
    w_resp.thread  = r_work.thread;
    w_resp.omode   = r_work.omode;
    w_resp.ip      = r_work.ip;
    w_resp.step    = r_work.step;
    w_resp.wr      = r_work.wr;
    w_resp.func    = r_work.func;
    w_resp.func2   = r_work.func2;
    w_resp.sz      = r_work.sz;
    w_resp.sel     = r_work.sel;
    w_resp.asid    = r_work.asid;
    w_resp.vcadr   = r_work.vcadr;
    w_resp.acr     = r_work.acr;
    w_resp.tgt     = r_work.tgt;
    w_resp.badAddr = r_work.adr;
    w_resp.cmt     = 1'b1;
    w_resp.empty   = (r_count == '0);
    w_resp.cause   = FLT_NONE;
    if (!w_is_load && !w_is_store) begin
      w_resp.cause = FLT_UNIMP;
    end else if (!w_in_range) begin
      w_resp.cause = FLT_PMA;
    end else if (w_is_load) begin
      w_resp.res   = {512'b0, r_line};
      w_resp.dat   = r_line[{r_work.adr[5:2], 5'b0} +: 32];
      w_resp.dchit = 1'b1;
      w_resp.hit   = 2'b01;
    end else begin
      w_resp.wr    = 1'b1;
    end
  end

endmodule

// File: tb/tb_rfphoenix_mem_responder.sv
// Directed testbench for rfphoenix_mem_responder: store/load, latency,
// backpressure and overflow, out-of-range, unsupported func and mid-response reset.
module tb_rfphoenix_mem_responder;
  import rfphoenix_mem_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  memory_request_t  req_i;
  logic             req_full_o;
  memory_response_t resp_o;
  logic             resp_ack_i;
  logic             ovf_o;

  int n_vec  = 0;
  int n_fail = 0;

  memory_request_t  rq;
  memory_response_t rs;

  rfphoenix_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .req_full_o (req_full_o),
    .resp_o     (resp_o),
    .resp_ack_i (resp_ack_i),
    .ovf_o      (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request for exactly one clock edge.
  task automatic offer(input memory_request_t r);
    req_i = r;
    @(posedge clk); #1;
    req_i = '0;
  endtask

  // Wait (bounded) for the next cycle with resp_o.v=1 and capture it.
  task automatic wait_resp(input string tag, output memory_response_t r);
    logic got;
    got = 1'b0;
    r   = '0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (resp_o.v) begin
        r   = resp_o;
        got = 1'b1;
        break;
      end
    end
    check({tag, "_arrived"}, 64'(got), 64'd1);
  endtask

  // Expect no response during a window of cycles.
  task automatic expect_no_resp(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (resp_o.v) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  function automatic memory_request_t mk(input mem_func_t f, input logic [31:0] adr,
                                         input logic [7:0] tid);
    memory_request_t r;
    r       = '0;
    r.v     = 1'b1;
    r.func  = f;
    r.adr   = adr;
    r.tid   = tid;
    r.ip    = 32'h1000 + 32'(tid);
    r.asid  = 10'h155;
    r.sel   = 64'h0;
    return r;
  endfunction

  initial begin
    req_i      = '0;
    rst        = 1'b1;
    resp_ack_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_v", 64'(resp_o.v), 64'd0);
    check("rst_resp_empty", 64'(resp_o.empty), 64'd1);
    check("rst_full", 64'(req_full_o), 64'd0);
    check("rst_ovf", 64'(ovf_o), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Store then load to the same line, back to back
    rq = mk(MR_STORE, 32'h40, 8'h11);
    rq.sel = 64'hF;
    rq.dat[31:0] = 32'hDEADBEEF;
    offer(rq);
    offer(mk(MR_LOAD, 32'h40, 8'h12));
`ifdef RFPHOENIX_STORE_ACK_EN
    wait_resp("st_ack", rs);
    check("st_ack_tid", 64'(rs.tid), 64'h11);
    check("st_ack_wr", 64'(rs.wr), 64'd1);
    check("st_ack_cmt", 64'(rs.cmt), 64'd1);
    check("st_ack_res0", 64'(|rs.res), 64'd0);
`endif
    wait_resp("ld1", rs);
    check("ld1_tid", 64'(rs.tid), 64'h12);
    check("ld1_dat", 64'(rs.dat), 64'hDEADBEEF);
    check("ld1_res_lo", 64'(rs.res[31:0]), 64'hDEADBEEF);
    check("ld1_res_hi0", 64'(|rs.res[1023:512]), 64'd0);
    check("ld1_cause", 64'(rs.cause), 64'(FLT_NONE));
    check("ld1_hit", 64'({rs.dchit, rs.hit}), 64'b101);
    check("ld1_ip", 64'(rs.ip), 64'h1012);
    check("ld1_badaddr", 64'(rs.badAddr), 64'h40);

    // Partial store into bytes 4..7 of line 2, then word 1 read-back
    rq = mk(MR_STORE, 32'h84, 8'h13);
    rq.sel = 64'hF0;
    rq.dat[63:32] = 32'hCAFEF00D;
    offer(rq);
`ifdef RFPHOENIX_STORE_ACK_EN
    wait_resp("st2", rs);
    check("st2_tid", 64'(rs.tid), 64'h13);
`else
    expect_no_resp("st2_silent", 8);
`endif
    repeat (4) @(posedge clk);
    #1;

    // Latency from push edge N to resp_o.v after N+3
    offer(mk(MR_LOAD, 32'h84, 8'h14));
    check("lat_n0", 64'(resp_o.v), 64'd0);
    @(posedge clk); #1;
    check("lat_n1", 64'(resp_o.v), 64'd0);
    @(posedge clk); #1;
    check("lat_n2", 64'(resp_o.v), 64'd0);
    @(posedge clk); #1;
    check("lat_n3", 64'(resp_o.v), 64'd1);
    check("lat_tid", 64'(resp_o.tid), 64'h14);
    check("lat_dat", 64'(resp_o.dat), 64'hCAFEF00D);
    check("lat_res_w1", 64'(resp_o.res[63:32]), 64'hCAFEF00D);
    check("lat_empty", 64'(resp_o.empty), 64'd1);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: ack held low, QDEPTH+1 accepted, one more dropped
    resp_ack_i = 1'b0;
    for (int i = 0; i < 5; i++) offer(mk(MR_LOAD, 32'h40, 8'(8'h20 + i)));
    check("bp_full", 64'(req_full_o), 64'd1);
    check("bp_ovf_before", 64'(ovf_o), 64'd0);
    check("bp_head_v", 64'(resp_o.v), 64'd1);
    offer(mk(MR_LOAD, 32'h40, 8'h25));
    check("bp_ovf_after", 64'(ovf_o), 64'd1);
    check("bp_full_hold", 64'(req_full_o), 64'd1);
    check("bp_head_tid", 64'(resp_o.tid), 64'h20);
    resp_ack_i = 1'b1;
    for (int i = 1; i < 5; i++) begin
      wait_resp("bp", rs);
      check("bp_order_tid", 64'(rs.tid), 64'(8'h20 + i));
    end
    check("bp_last_dat", 64'(rs.dat), 64'hDEADBEEF);
    expect_no_resp("bp_dropped", 10);
    check("bp_full_clear", 64'(req_full_o), 64'd0);

    // Out-of-range load and store
    offer(mk(MR_LOAD, 32'h00010000, 8'h30));
    wait_resp("oor_ld", rs);
    check("oor_ld_cause", 64'(rs.cause), 64'(FLT_PMA));
    check("oor_ld_badaddr", 64'(rs.badAddr), 64'h00010000);
    check("oor_ld_res0", 64'(|rs.res), 64'd0);
    rq = mk(MR_STORE, 32'h00010040, 8'h31);
    rq.sel = '1;
    rq.dat = '1;
    offer(rq);
    wait_resp("oor_st", rs);
    check("oor_st_tid", 64'(rs.tid), 64'h31);
    check("oor_st_cause", 64'(rs.cause), 64'(FLT_PMA));
    offer(mk(MR_LOAD, 32'h40, 8'h32));
    wait_resp("oor_chk", rs);
    check("oor_ram_intact", 64'(rs.dat), 64'hDEADBEEF);

    // Unsupported func
    offer(mk(MR_TLB, 32'h40, 8'h50));
    wait_resp("unimp", rs);
    check("unimp_tid", 64'(rs.tid), 64'h50);
    check("unimp_cause", 64'(rs.cause), 64'(FLT_UNIMP));
    check("unimp_cmt", 64'(rs.cmt), 64'd1);
    check("unimp_func", 64'(rs.func), 64'(MR_TLB));

    // Reset while a response waits for ack
    resp_ack_i = 1'b0;
    offer(mk(MR_LOAD, 32'h40, 8'h60));
    wait_resp("rr_pre", rs);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rr_resp_v", 64'(resp_o.v), 64'd0);
    check("rr_full", 64'(req_full_o), 64'd0);
    check("rr_ovf", 64'(ovf_o), 64'd0);
    check("rr_empty", 64'(resp_o.empty), 64'd1);
    rst        = 1'b0;
    resp_ack_i = 1'b1;
    @(posedge clk); #1;
    offer(mk(MR_LOADZ, 32'h40, 8'h61));
    wait_resp("rr_post", rs);
    check("rr_post_tid", 64'(rs.tid), 64'h61);
    check("rr_post_dat", 64'(rs.dat), 64'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/rfphoenix_mem_responder.md
Name: rfphoenix_mem_responder

Overview:
Memory-side responder for the core's MemoryRequest/MemoryResponse protocol: it is the slave end that the L1/ICache/TLB request path talks to. It buffers incoming requests in a small FIFO and services them in order against an on-chip 512-bit-line RAM. Loads, stores and unsupported operations each get one MemoryResponse, returned under a valid/ack handshake. It is used as the backing memory in simulation and small FPGA builds.

Parameters:
LINES, 1024, number of 512-bit lines in the RAM; address bits adr[5:0] are the byte offset within a line, and adr[6+$clog2(LINES)-1:6] is the line index.
QDEPTH, 4, request FIFO depth; must be a power of two and at least 2.
BASE, 32'h00000000, base address; an address is in range when BASE <= adr < BASE+LINES*64.

Ports:
clk  input  1  clock.
rst  input  1  reset, synchronous, active-high.
req_i  input  MemoryRequest  request bus; req_i.v=1 offers a request.
req_full_o  output  1  FIFO full; the requester must not offer a request while this is 1.
resp_o  output  MemoryResponse  response bus; resp_o.v=1 presents a response.
resp_ack_i  input  1  consumer accepts resp_o during a cycle in which resp_o.v=1.
ovf_o  output  1  sticky flag; set when a request is offered while req_full_o=1.

Behaviour:
- Reset (rst=1 at a clk edge) clears the following, and holds until rst drops:
  - FIFO pointers and count, and the FSM (to IDLE).
  - req_full_o=0, ovf_o=0.
  - resp_o all-zero except resp_o.empty=1.
- Reset mid-operation: any in-flight request and any unacknowledged response are discarded. RAM contents are not cleared.
- FIFO push:
  - req_i.v=1 && !req_full_o writes the request into the FIFO at the clock edge.
  - req_full_o is registered and equals (count==QDEPTH).
  - A push and an FSM pop in the same cycle leave the count unchanged.
  - req_i.v=1 while req_full_o=1: the request is dropped and ovf_o sets. ovf_o stays set until rst.
- FSM states: IDLE, RD, RESP.
  - IDLE: if the FIFO is non-empty, pop the head into the working register and go to RD. Otherwise stay in IDLE.
  - RD: perform the RAM access (synchronous, one cycle), then go to RESP.
  - RESP: resp_o.v=1. On resp_ack_i, go to IDLE.
  - resp_o is held stable until acked.
- Latency: a request pushed at edge N into an empty idle block is popped at N+1, accessed at N+2, and has resp_o.v=1 after edge N+3. Steady-state throughput is one request per 3 cycles plus the ack wait.
- Request handling by func:
  - MR_LOAD and MR_LOADZ:
    - res[511:0] = addressed line; res[1023:512] = 0.
    - dat = 32-bit word at adr[5:2], little-endian.
    - dchit=1, hit=2'b01.
  - MR_STORE:
    - For each i where sel[i]=1, byte i of the line takes dat[8*i+7:8*i].
    - The write occurs in RD.
    - Whether a response is generated is set by the optional feature below.
  - Any other func: no RAM effect; cause=FLT_UNIMP.
  - Address out of range: no RAM effect; cause=FLT_PMA; res=0.
  - Otherwise cause=FLT_NONE.
- Response fields:
  - Copied from the request: tid, thread, omode, ip, step, wr, func, func2, sz, sel, asid, vcadr, acr, tgt.
  - badAddr = adr.
  - cmt=1.
  - empty = FIFO empty at the time of the response.
  - tlb_access, ptgram_en, rgn_en and pmtram_ena are 0.
- Ordering: responses are returned strictly in request order.
- Store then load to the same line: the load observes the store data, because RAM accesses are serialized.

Optional Feature:
Macro RFPHOENIX_STORE_ACK_EN.
- Defined: MR_STORE produces a response with wr=1, cmt=1 and res=0, through the normal RESP handshake.
- Undefined: MR_STORE goes RD->IDLE with no response (resp_o.v stays 0). Faulting stores, whether unimplemented func or out of range, still respond so the fault is reported.

Test Plan:
1. Store then load, macro defined:
   - Stimulus: STORE adr=32'h40, sel=64'hF, dat[31:0]=32'hDEADBEEF, tid=8'h11; then LOAD adr=32'h40, tid=8'h12; resp_ack_i tied to 1.
   - Required: two responses in order. The first has tid=8'h11, wr=1. The second has tid=8'h12, dat=32'hDEADBEEF, res[31:0]=32'hDEADBEEF, cause=FLT_NONE.
2. Latency:
   - Stimulus: single LOAD pushed at edge N into an idle, empty block.
   - Required: resp_o.v rises after edge N+3.
3. Backpressure:
   - Stimulus: resp_ack_i=0, push QDEPTH+1 LOADs.
   - Required: the FSM holds the first request in RESP and QDEPTH more fill the FIFO. req_full_o=1 once count reaches 4. One further offered request sets ovf_o=1 and is dropped. After ack is released, the 5 accepted requests return in tid order.
4. Out-of-range address:
   - Stimulus: LOAD adr=BASE+LINES*64.
   - Required: cause=FLT_PMA, badAddr equals that address, RAM unchanged.
5. Unsupported func:
   - Stimulus: request with func=MR_TLB.
   - Required: cause=FLT_UNIMP, cmt=1.
6. Reset mid-response:
   - Stimulus: rst=1 while in RESP with resp_ack_i=0.
   - Required: the next cycle has resp_o.v=0, req_full_o=0, ovf_o=0. A later LOAD of previously stored data still returns that data.
